// File: rtl/phase_marker_injector.sv
// phase_marker_injector: encodes phase START/END requests into marker words, queues them and
// injects them on a valid/ready port, tracking open phases, illegal requests and injection stalls.
module phase_marker_injector #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_phase,
    input  logic             req_end,
    output logic             inj_valid,
    input  logic             inj_ready,
    output logic [31:0]      inj_inst,
    output logic [6:0]       open_mask,
    output logic [CNT_W-1:0] issued_cnt,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic             stall
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STALLED} st_t;

    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      mem_d [DEPTH];
    logic [6:0]       open_q, open_d;
    logic [CNT_W-1:0] issued_q, issued_d, err_q, err_d;
    logic             err_pulse_q, err_pulse_d;
    st_t              st_q;
    logic [TW-1:0]    timer_q;
    logic             stall_q;
    logic [7:0]       open_ext;
    logic             accept, illegal, push, pop, waiting;
    logic [31:0]      word;

    assign req_ready  = cnt_q != CW'(DEPTH);
    assign inj_valid  = cnt_q != '0;
    assign inj_inst   = inj_valid ? mem_q[rd_q] : '0;
    assign open_mask  = open_q;
    assign issued_cnt = issued_q;
    assign err_cnt    = err_q;
    assign err_pulse  = err_pulse_q;
    assign stall      = stall_q;

    // Phase 7 indexes the padding bit, so it always reads as closed.
    assign open_ext = {1'b0, open_q};
    assign accept   = req_valid && req_ready;
    assign illegal  = (&req_phase) || (req_end != open_ext[req_phase]);
    assign push     = accept && !illegal;
    assign pop      = inj_valid && inj_ready;
    assign waiting  = inj_valid && !inj_ready;
    assign word     = {8'h00, req_phase, req_end, 20'h02013};

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_q] = word;
        open_d = open_q;
        if (push) open_d[req_phase] = !req_end;
        wr_d        = wr_q + AW'(push);
        rd_d        = rd_q + AW'(pop);
        cnt_d       = cnt_q + CW'(push) - CW'(pop);
        issued_d    = (pop && !(&issued_q)) ? issued_q + CNT_W'(1) : issued_q;
        err_pulse_d = accept && illegal;
        err_d       = (err_pulse_d && !(&err_q)) ? err_q + CNT_W'(1) : err_q;
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            open_q      <= '0;
            issued_q    <= '0;
            err_q       <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            open_q      <= open_d;
            issued_q    <= issued_d;
            err_q       <= err_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    // Once stalled, only reset clears the flag; injection itself keeps running.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st_q    <= S_IDLE;
            timer_q <= '0;
            stall_q <= 1'b0;
        end else begin
            case (st_q)
                S_IDLE: begin
                    if (waiting) begin
                        st_q    <= S_WAIT;
                        timer_q <= TW'(1);
                    end
                end
                S_WAIT: begin
                    if (!waiting) begin
                        st_q    <= S_IDLE;
                        timer_q <= '0;
                    end else if (timer_q == TW'(TIMEOUT)) begin
                        st_q    <= S_STALLED;
                        stall_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_STALLED: st_q <= S_STALLED;
                default:   st_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_phase_marker_injector.sv
// tb_phase_marker_injector: directed checks of encoding, ordering, back-pressure, illegal
// requests, stall timeout and mid-operation reset.
module tb_phase_marker_injector;

    logic        clock, reset, req_valid, req_ready, req_end;
    logic [2:0]  req_phase;
    logic        inj_valid, inj_ready, err_pulse, stall;
    logic [31:0] inj_inst;
    logic [6:0]  open_mask;
    logic [15:0] issued_cnt, err_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          acc_n, errp_n;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    phase_marker_injector #(.DEPTH(4), .TIMEOUT(8), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_phase(req_phase), .req_end(req_end), .inj_valid(inj_valid),
        .inj_ready(inj_ready), .inj_inst(inj_inst), .open_mask(open_mask),
        .issued_cnt(issued_cnt), .err_pulse(err_pulse), .err_cnt(err_cnt), .stall(stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset) begin
            got_q.delete();
            acc_n  = 0;
            errp_n = 0;
        end else begin
            if (inj_valid && inj_ready) got_q.push_back(inj_inst);
            if (req_valid && req_ready) acc_n++;
            if (err_pulse) errp_n++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = 1'b0; req_phase = '0; req_end = 1'b0; inj_ready = 1'b0;
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic req(input logic [2:0] p, input logic e);
        int n = 0;
        req_valid = 1'b1; req_phase = p; req_end = e;
        while (!req_ready && n < 50) begin
            cyc(1);
            n++;
        end
        if (n == 50) check("req_ready_wait", {31'b0, req_ready}, 32'd1);
        cyc(1);
        req_valid = 1'b0;
    endtask

    task automatic chk_words(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        do_reset();
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_inj_valid", {31'b0, inj_valid}, 32'd0);
        check("rst_inj_inst", inj_inst, 32'h0);
        check("rst_open", {25'b0, open_mask}, 32'd0);
        check("rst_issued", {16'b0, issued_cnt}, 32'd0);
        check("rst_err", {16'b0, err_cnt}, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);

        // Single VCTM START
        inj_ready = 1'b1;
        req(3'd0, 1'b0);
        check("t1_valid", {31'b0, inj_valid}, 32'd1);
        check("t1_inst", inj_inst, 32'h00002013);
        cyc(1);
        check("t1_issued", {16'b0, issued_cnt}, 32'd1);
        check("t1_open", {25'b0, open_mask}, 32'h01);
        check("t1_empty", {31'b0, inj_valid}, 32'd0);

        // Ordered sequence
        do_reset();
        inj_ready = 1'b1;
        req(3'd4, 1'b0); req(3'd4, 1'b1); req(3'd6, 1'b0); req(3'd6, 1'b1); req(3'd3, 1'b0);
        cyc(3);
        exp_q = '{32'h00802013, 32'h00902013, 32'h00c02013, 32'h00d02013, 32'h00602013};
        chk_words("t2");
        check("t2_open", {25'b0, open_mask}, 32'h08);
        check("t2_issued", {16'b0, issued_cnt}, 32'd5);

        // Back-pressure with a full FIFO
        do_reset();
        req(3'd0, 1'b0); req(3'd1, 1'b0); req(3'd2, 1'b0); req(3'd3, 1'b0);
        req_valid = 1'b1; req_phase = 3'd4; req_end = 1'b0;
        cyc(2);
        check("t3_full_ready", {31'b0, req_ready}, 32'd0);
        check("t3_acc4", acc_n, 32'd4);
        check("t3_head", inj_inst, 32'h00002013);
        inj_ready = 1'b1;
        cyc(1);
        check("t3_pop_ready", {31'b0, req_ready}, 32'd1);
        check("t3_pop_acc", acc_n, 32'd4);
        check("t3_pop_issued", {16'b0, issued_cnt}, 32'd1);
        cyc(1);
        check("t3_acc5", acc_n, 32'd5);
        req_valid = 1'b0;
        cyc(6);
        check("t3_issued", {16'b0, issued_cnt}, 32'd5);
        exp_q = '{32'h00002013, 32'h00202013, 32'h00402013, 32'h00602013, 32'h00802013};
        chk_words("t3");

        // Illegal requests
        do_reset();
        inj_ready = 1'b1;
        req(3'd1, 1'b1);
        check("t4_pulse1", {31'b0, err_pulse}, 32'd1);
        req(3'd0, 1'b0);
        check("t4_pulse_legal", {31'b0, err_pulse}, 32'd0);
        req(3'd0, 1'b0);
        check("t4_pulse2", {31'b0, err_pulse}, 32'd1);
        req(3'd7, 1'b0);
        cyc(3);
        check("t4_err_cnt", {16'b0, err_cnt}, 32'd3);
        check("t4_pulses", errp_n, 32'd3);
        check("t4_open", {25'b0, open_mask}, 32'h01);
        exp_q = '{32'h00002013};
        chk_words("t4");

        // Stall timeout
        do_reset();
        req(3'd3, 1'b0);
        check("t5_valid", {31'b0, inj_valid}, 32'd1);
        cyc(7);
        check("t5_no_stall", {31'b0, stall}, 32'd0);
        cyc(3);
        check("t5_stall", {31'b0, stall}, 32'd1);
        check("t5_held", inj_inst, 32'h00602013);
        inj_ready = 1'b1;
        cyc(1);
        check("t5_issued", {16'b0, issued_cnt}, 32'd1);
        check("t5_drained", {31'b0, inj_valid}, 32'd0);
        cyc(2);
        check("t5_sticky", {31'b0, stall}, 32'd1);

        // Reset mid-operation
        do_reset();
        req(3'd0, 1'b0); req(3'd1, 1'b0); req(3'd2, 1'b0);
        check("t6_open_pre", {25'b0, open_mask}, 32'h07);
        check("t6_valid_pre", {31'b0, inj_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t6_valid", {31'b0, inj_valid}, 32'd0);
        check("t6_inst", inj_inst, 32'h0);
        check("t6_open", {25'b0, open_mask}, 32'd0);
        check("t6_issued", {16'b0, issued_cnt}, 32'd0);
        check("t6_err", {16'b0, err_cnt}, 32'd0);
        cyc(1);
        reset = 1'b0;
        inj_ready = 1'b1;
        cyc(5);
        check("t6_no_xfer", got_q.size(), 32'd0);
        check("t6_issued_post", {16'b0, issued_cnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
